// File: rtl/recipe_pkg.sv
// Shared types and helpers for the beverage recipe sequencer.
//   state_e     : 3-bit FSM state encoding (values 4..7 are illegal)
//   dose_slice  : extracts one per-stage dose field from a flattened dose bus
package recipe_pkg;

    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_DOSE_W     = 8;

    // Upper bounds the dose helper is sized for (16 stages, doses up to 32 bits).
    localparam int unsigned MAX_STAGES = 16;
    localparam int unsigned MAX_DOSE_W = 32;
    localparam int unsigned MAX_FLAT_W = MAX_STAGES * MAX_DOSE_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPENSE = 3'd1,
        ST_DONE     = 3'd2,
        ST_ABORTED  = 3'd3
    } state_e;

    // Dose field idx of width dose_w, zero-extended to MAX_DOSE_W.
    function automatic logic [MAX_DOSE_W-1:0] dose_slice(
        input logic [MAX_FLAT_W-1:0] flat,
        input int unsigned           idx,
        input int unsigned           dose_w
    );
        logic [MAX_FLAT_W-1:0] shifted;
        logic [MAX_DOSE_W-1:0] field_mask;
        shifted    = flat >> (idx * dose_w);
        field_mask = (dose_w >= MAX_DOSE_W) ? '1
                   : ((MAX_DOSE_W'(1) << dose_w) - MAX_DOSE_W'(1));
        return shifted[MAX_DOSE_W-1:0] & field_mask;
    endfunction

endpackage

// File: rtl/recipe_sequencer_next_stage_finder.sv
// Combinational priority encoder: finds the lowest set bit of eff_vec that is
// strictly above cur_idx, or the lowest set bit overall when from_start is high.
//   eff_vec    : effective-stage vector
//   cur_idx    : currently active stage
//   from_start : ignore cur_idx and search from stage 0
//   next_idx   : index of the stage found (0 when none)
//   found      : a qualifying stage exists
module next_stage_finder
    import recipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic [NUM_STAGES-1:0] eff_vec,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  from_start,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  found
);

    // Scan high to low so the lowest qualifying stage is the last one written.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            if (eff_vec[i] && (from_start || (i > int'(cur_idx)))) begin
                next_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recipe_sequencer.sv
// Beverage recipe sequencer: steps through enabled ingredient stages in order,
// opening one valve per stage until the comparator has delivered that stage's
// dose, with start, abort and finish/abort acknowledge handshakes.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start               : begin a recipe (IDLE only); latches recipe_mask and dose
//   recipe_mask, dose   : stage enables and flattened per-stage pulse targets
//   result              : comparator pulse, one dose unit per high cycle
//   abort, ack          : cancel running recipe / clear DONE or ABORTED
//   valve               : one-hot valve enable of the active stage
//   busy/finished/aborted, stage_idx, state_output : status and debug
// DOSE_W is supported up to 32 bits; NUM_STAGES from 2 to 16.
module recipe_sequencer
    import recipe_pkg::*;
#(
    parameter  int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter  int unsigned DOSE_W     = DEF_DOSE_W,
    localparam int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_STAGES-1:0]        recipe_mask,
    input  logic [NUM_STAGES*DOSE_W-1:0] dose,
    input  logic                         result,
    input  logic                         abort,
    input  logic                         ack,
    output logic [NUM_STAGES-1:0]        valve,
    output logic                         busy,
    output logic                         finished,
    output logic                         aborted,
    output logic [IDX_W-1:0]             stage_idx,
    output logic [2:0]                   state_output
);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            stage_q, stage_d;
    logic [DOSE_W-1:0]           cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]       mask_q, mask_d;
    logic [NUM_STAGES*DOSE_W-1:0] dose_q, dose_d;
    logic [NUM_STAGES-1:0]       valve_q, valve_d;
    logic                        busy_q, busy_d;
    logic                        finished_q, finished_d;
    logic                        aborted_q, aborted_d;

    logic [NUM_STAGES-1:0] eff_in, eff_lat, find_vec;
    logic                  find_from_start;
    logic [IDX_W-1:0]      next_idx;
    logic                  next_found;
    logic [DOSE_W-1:0]     dose_cur;
    logic [DOSE_W-1:0]     cnt_inc;

    // Effective stages: from live inputs (for the start decision) and from latches.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            eff_in[i]  = recipe_mask[i] &&
                         (dose_slice(MAX_FLAT_W'(dose), i, DOSE_W) != '0);
            eff_lat[i] = mask_q[i] &&
                         (dose_slice(MAX_FLAT_W'(dose_q), i, DOSE_W) != '0);
        end
    end

    // In IDLE the finder looks for the first stage of the incoming recipe,
    // otherwise for the next stage after the active one.
    assign find_from_start = (state_q == ST_IDLE);
    assign find_vec        = find_from_start ? eff_in : eff_lat;

    next_stage_finder #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_next_stage_finder (
        .eff_vec    (find_vec),
        .cur_idx    (stage_q),
        .from_start (find_from_start),
        .next_idx   (next_idx),
        .found      (next_found)
    );

    assign dose_cur = DOSE_W'(dose_slice(MAX_FLAT_W'(dose_q), 32'(stage_q), DOSE_W));
    assign cnt_inc  = cnt_q + DOSE_W'(1);

    // Next-state logic; outputs are decoded from the next state and registered.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dose_d  = dose_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = recipe_mask;
                    dose_d = dose;
                    cnt_d  = '0;
                    if (next_found) begin
                        stage_d = next_idx;
                        state_d = ST_DISPENSE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DISPENSE: begin
                // Abort wins over a same-cycle stage completion.
                if (abort) begin
                    state_d = ST_ABORTED;
                end else if (result) begin
                    if (cnt_inc == dose_cur) begin
                        cnt_d = '0;
                        if (next_found) begin
                            stage_d = next_idx;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DONE, ST_ABORTED: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valve_d    = '0;
        busy_d     = (state_d == ST_DISPENSE);
        finished_d = (state_d == ST_DONE);
        aborted_d  = (state_d == ST_ABORTED);
        if (state_d == ST_DISPENSE) begin
            valve_d = NUM_STAGES'(1) << stage_d;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            dose_q     <= '0;
            valve_q    <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            dose_q     <= dose_d;
            valve_q    <= valve_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            aborted_q  <= aborted_d;
        end
    end

    assign valve        = valve_q;
    assign busy         = busy_q;
    assign finished     = finished_q;
    assign aborted      = aborted_q;
    assign stage_idx    = stage_q;
    assign state_output = state_q;

endmodule

// File: tb/tb_recipe_sequencer.sv
// Self-checking bench for recipe_sequencer: directed recipes from the test plan
// plus randomized recipes, all checked cycle by cycle against a queue-based
// model of which stage should be dispensing.
module tb_recipe_sequencer;

    localparam int unsigned NS      = 5;
    localparam int unsigned DW      = 8;
    localparam int unsigned IW      = 3;
    localparam int unsigned FLAT_W  = NS * DW;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [NS-1:0]     recipe_mask;
    logic [FLAT_W-1:0] dose;
    logic              result;
    logic              abort;
    logic              ack;
    logic [NS-1:0]     valve;
    logic              busy;
    logic              finished;
    logic              aborted;
    logic [IW-1:0]     stage_idx;
    logic [2:0]        state_output;

    int n_tests = 0;
    int n_fail  = 0;

    recipe_sequencer #(
        .NUM_STAGES (NS),
        .DOSE_W     (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .recipe_mask  (recipe_mask),
        .dose         (dose),
        .result       (result),
        .abort        (abort),
        .ack          (ack),
        .valve        (valve),
        .busy         (busy),
        .finished     (finished),
        .aborted      (aborted),
        .stage_idx    (stage_idx),
        .state_output (state_output)
    );

    always #5 clock = ~clock;

    function automatic logic [FLAT_W-1:0] pack5(input int d0, input int d1, input int d2,
                                                input int d3, input int d4);
        logic [FLAT_W-1:0] v;
        v = {DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
        return v;
    endfunction

    // Runs one recipe start-to-ack. mode 0: result held high, 1: random result,
    // 2: result taken from rpat (LSB = first dispensing cycle, 1 after bit 31).
    // abort_cyc: dispensing cycle on which abort is raised (-1 = never).
    task automatic run_recipe(input string name, input logic [NS-1:0] m,
                              input logic [FLAT_W-1:0] d, input int mode,
                              input logic [31:0] rpat, input int abort_cyc);
        int   q[$];
        int   pos;
        int   rem;
        int   cyc;
        logic r;
        logic ab;
        logic was_aborted;
        logic [2:0] exp_st;
        logic [DW-1:0] dv;

        for (int i = 0; i < int'(NS); i++) begin
            dv = d[i*DW +: DW];
            if (m[i] && dv != '0) q.push_back(i);
        end

        recipe_mask = m;
        dose        = d;
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
        // Inputs may wander after the latch without effect.
        recipe_mask = NS'($urandom());
        dose        = FLAT_W'({$urandom(), $urandom()});

        pos         = 0;
        rem         = 0;
        if (q.size() > 0) rem = int'(d[q[0]*DW +: DW]);
        cyc         = 0;
        was_aborted = 1'b0;

        while (pos < q.size() && !was_aborted) begin
            n_tests++;
            if (valve !== NS'(1 << q[pos]) || busy !== 1'b1 || finished !== 1'b0 ||
                aborted !== 1'b0 || stage_idx !== IW'(q[pos]) || state_output !== 3'd1) begin
                n_fail++;
                $display("FAIL %s dispense cyc%0d: valve=%b busy=%b fin=%b abt=%b stage=%0d st=%0d, want valve=%b busy=1 fin=0 abt=0 stage=%0d st=1",
                         name, cyc, valve, busy, finished, aborted, stage_idx, state_output,
                         NS'(1 << q[pos]), q[pos]);
            end
            if (cyc > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: still dispensing after %0d cycles, want DONE", name, cyc);
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc < 32) ? rpat[cyc] : 1'b1;
            endcase
            ab     = (cyc == abort_cyc);
            result = r;
            abort  = ab;
            @(posedge clock); #1;
            result = 1'b0;
            abort  = 1'b0;
            cyc++;
            if (ab) begin
                was_aborted = 1'b1;
            end else if (r) begin
                rem--;
                if (rem == 0) begin
                    pos++;
                    if (pos < q.size()) rem = int'(d[q[pos]*DW +: DW]);
                end
            end
        end

        exp_st = was_aborted ? 3'd3 : 3'd2;
        n_tests++;
        if (state_output !== exp_st || valve !== '0 || busy !== 1'b0 ||
            finished !== !was_aborted || aborted !== was_aborted) begin
            n_fail++;
            $display("FAIL %s end: st=%0d valve=%b busy=%b fin=%b abt=%b, want st=%0d valve=0 busy=0 fin=%b abt=%b",
                     name, state_output, valve, busy, finished, aborted, exp_st,
                     !was_aborted, was_aborted);
        end
        if (was_aborted) begin
            n_tests++;
            if (stage_idx !== IW'(q[pos])) begin
                n_fail++;
                $display("FAIL %s abort stage: stage=%0d, want %0d", name, stage_idx, q[pos]);
            end
        end

        // start and abort must be ignored while holding DONE/ABORTED.
        start       = 1'b1;
        abort       = 1'b1;
        recipe_mask = '1;
        dose        = pack5(1, 1, 1, 1, 1);
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        n_tests++;
        if (state_output !== exp_st || valve !== '0 || finished !== !was_aborted ||
            aborted !== was_aborted) begin
            n_fail++;
            $display("FAIL %s hold: st=%0d valve=%b fin=%b abt=%b, want st=%0d valve=0",
                     name, state_output, valve, finished, aborted, exp_st);
        end

        ack = 1'b1;
        @(posedge clock); #1;
        ack = 1'b0;
        n_tests++;
        if (state_output !== 3'd0 || valve !== '0 || busy !== 1'b0 ||
            finished !== 1'b0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack: st=%0d valve=%b busy=%b fin=%b abt=%b, want IDLE with all low",
                     name, state_output, valve, busy, finished, aborted);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; result = 1'b0; abort = 1'b0; ack = 1'b0;
        recipe_mask = '0; dose = '0;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (state_output !== 3'd0 || valve !== '0 || busy !== 1'b0 || finished !== 1'b0 ||
            aborted !== 1'b0 || stage_idx !== '0) begin
            n_fail++;
            $display("FAIL reset: st=%0d valve=%b busy=%b fin=%b abt=%b stage=%0d, want all zero",
                     state_output, valve, busy, finished, aborted, stage_idx);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_sequence();
        run_recipe("full", 5'b11111, pack5(2, 1, 3, 1, 1), 0, 32'h0, -1);
    endtask

    task automatic test_sparse_mask();
        run_recipe("sparse", 5'b10101, pack5(1, 9, 2, 9, 1), 0, 32'h0, -1);
    endtask

    task automatic test_no_effective();
        run_recipe("zero_dose", 5'b00110, pack5(4, 0, 0, 4, 4), 0, 32'h0, -1);
        run_recipe("zero_mask", 5'b00000, pack5(1, 2, 3, 4, 5), 0, 32'h0, -1);
    endtask

    task automatic test_gapped_result();
        // Stage 2 (dose 3) sees pulses 1,1,0,0,1 after stages 0 and 1 finish.
        run_recipe("gapped", 5'b11111, pack5(1, 1, 3, 1, 1), 2, 32'hFFFF_FFCF, -1);
    endtask

    task automatic test_abort();
        // Abort lands on the completing pulse of stage 1.
        run_recipe("abort", 5'b11111, pack5(2, 1, 3, 1, 1), 0, 32'h0, 2);
    endtask

    task automatic test_reset_midrecipe();
        recipe_mask = 5'b11111;
        dose        = pack5(1, 1, 5, 1, 1);
        start       = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        result = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        result = 1'b0;
        n_tests++;
        if (valve !== 5'b00100) begin
            n_fail++;
            $display("FAIL midreset pre: valve=%b, want 00100", valve);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (valve !== '0 || busy !== 1'b0 || state_output !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset async: valve=%b busy=%b st=%0d, want 0 0 0",
                     valve, busy, state_output);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_tests++;
        if (state_output !== 3'd0 || valve !== '0) begin
            n_fail++;
            $display("FAIL midreset idle: st=%0d valve=%b, want 0 0", state_output, valve);
        end
        run_recipe("after_reset", 5'b01011, pack5(2, 3, 0, 1, 0), 0, 32'h0, -1);
    endtask

    task automatic test_random();
        logic [NS-1:0]     m;
        logic [FLAT_W-1:0] d;
        int                ac;
        for (int it = 0; it < 25; it++) begin
            m  = NS'($urandom());
            d  = pack5($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_recipe("random", m, d, 1, 32'h0, ac);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_sparse_mask();
        test_no_effective();
        test_gapped_result();
        test_abort();
        test_reset_midrecipe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
